spram_stream_reader: RTL and testbench

- Sequential read-back engine for a single_port_ram holding WIDTH-bit words, addressed with ADDR_W bits.
- On a start pulse it reads `length` consecutive words beginning at `base_addr` and streams them out over a valid/ready interface.
- It is the read-side counterpart of the address-counter write path that fills the RAM. A 2-entry output buffer absorbs the RAM's 1-cycle read latency and downstream back-pressure.

---
 rtl/spram_stream_reader.sv | 155 +++++++++++++++
 tb/tb_spram_stream_reader.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_stream_reader.sv
// ---------------------------------------------------------------------------
// spram_stream_reader
//
// Sequential read-back engine for a single-port RAM. A start pulse captures
// base_addr and length. The engine then reads `length` consecutive words,
// wrapping the address modulo 2^ADDR_W, and streams them out over a
// valid/ready interface. A 2-entry output FIFO absorbs the RAM's 1-cycle read
// latency and any downstream back-pressure.
//
// Ports:
//   clock      - system clock, all state changes on posedge
//   reset_n    - synchronous active-low reset
//   start      - begin a burst (only honoured in IDLE)
//   base_addr  - first RAM address of the burst (captured with start)
//   length     - number of words 0..2^ADDR_W (captured with start)
//   ram_addr   - RAM address (holds last issued address when idle/stalled)
//   ram_we     - RAM write enable, tied low
//   ram_rdata  - RAM read data, valid the cycle after ram_addr is sampled
//   value_out  - stream data (head of output FIFO, 0 when empty)
//   out_valid  - value_out holds a word
//   out_ready  - consumer accepts value_out this cycle
//   busy       - burst in progress
//   done       - one-cycle pulse after the last word has been accepted
// ---------------------------------------------------------------------------
module spram_stream_reader #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic [WIDTH-1:0]  value_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W:0]   remaining;

    logic [WIDTH-1:0]  buf_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        buf_count;
    logic              inflight;
    logic              done_q;

    logic              accept_start;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic [1:0]        occupancy;

    // A burst only starts from IDLE, and a zero-length request is a no-op.
    assign accept_start = (state == IDLE) && start && (length != '0);

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_start) state_next = READ;
            READ:    if (issue && (remaining == REM_ONE)) state_next = DRAIN;
            DRAIN:   if (last_pop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / control decode.
    // Occupancy counts buffered words plus the word still coming back from
    // the RAM. A read is issued only if that word is guaranteed a free FIFO
    // slot once this cycle's pop (if any) is taken into account.
    always_comb begin
        out_valid = (buf_count != 2'd0);
        value_out = out_valid ? buf_mem[rd_ptr] : '0;
        pop       = out_valid && out_ready;
        occupancy = buf_count + {1'b0, inflight};
        issue     = (state == READ) && (remaining != '0) &&
                    ((occupancy - {1'b0, pop}) < 2'd2);
        last_pop  = (state == DRAIN) && pop && (buf_count == 2'd1) && !inflight;
        ram_addr  = issue ? addr : ram_addr_q;
        ram_we    = 1'b0;
        busy      = (state != IDLE);
        done      = done_q;
    end

    // Address/length counters, in-flight tracking and FIFO pointers.
    // The in-flight flag marks that ram_rdata will be valid for capture at
    // the next edge. Clearing it on reset makes sure a word that was still
    // coming back from the RAM is never pushed into the FIFO.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            addr       <= '0;
            remaining  <= '0;
            ram_addr_q <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            buf_count  <= 2'd0;
            inflight   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q   <= last_pop;
            inflight <= issue;
            if (accept_start) begin
                addr      <= base_addr;
                remaining <= length;
            end else if (issue) begin
                addr       <= addr + 1'b1;
                remaining  <= remaining - 1'b1;
                ram_addr_q <= addr;
            end
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // FIFO storage needs no reset: value_out is masked while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (reset_n && inflight) begin
            buf_mem[wr_ptr] <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_spram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_spram_stream_reader
//
// Directed testbench for spram_stream_reader. A behavioural RAM holds
// mem[i] = i*3 and answers one cycle after each address. Every scenario task
// drives its own stimulus and checks the results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_spram_stream_reader;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] value_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic [15:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Consumer ready pattern, bit c%6: 1,0,0,1,0,1
    logic [5:0] ready_pat = 6'b101001;

    // Results gathered by the stream collector
    logic [15:0] got[$];
    logic [7:0]  addr_log[$];
    int          done_count;
    int          stall_viol;
    int          first_valid;
    int          first_hs;
    int          last_hs;
    int          done_cyc;
    int          busy_seen;
    logic        busy_at_done;

    always #5 clock = ~clock;

    // Behavioural RAM with 1-cycle read latency
    always @(posedge clock) begin
        ram_rdata <= mem[ram_addr];
    end

    spram_stream_reader #(
        .WIDTH (16),
        .ADDR_W(8)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .base_addr(base_addr),
        .length   (length),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata),
        .value_out(value_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    // All tasks assume they are entered 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start-pulse driver; returns in the cycle after the start edge (cycle 0).
    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Stream collector: runs a fixed number of cycles, records accepted
    // words, timing of the first valid/handshakes/done, and stall stability.
    task automatic collect(input int budget, input int ready_mode, input int restart_c);
        logic        prev_stall;
        logic [15:0] prev_val;
        got.delete();
        addr_log.delete();
        done_count   = 0;
        stall_viol   = 0;
        first_valid  = -1;
        first_hs     = -1;
        last_hs      = -1;
        done_cyc     = -1;
        busy_seen    = 0;
        busy_at_done = 1'b0;
        prev_stall   = 1'b0;
        prev_val     = '0;
        for (int c = 0; c < budget; c++) begin
            out_ready = (ready_mode == 0) ? 1'b1 : ready_pat[c % 6];
            start     = (c == restart_c);
            if (c < 4) addr_log.push_back(ram_addr);
            if (busy) busy_seen++;
            if (out_valid && first_valid < 0) first_valid = c;
            if (prev_stall && (!out_valid || value_out !== prev_val)) stall_viol++;
            if (done) begin
                done_count++;
                done_cyc     = c;
                busy_at_done = busy;
            end
            if (out_valid && out_ready) begin
                got.push_back(value_out);
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_val   = value_out;
            step();
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: busy=%b done=%b valid=%b expected 0 0 0", busy, done, out_valid);
        end
        checks++;
        if (value_out !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_value: got %h expected 0000", value_out);
        end
        checks++;
        if (ram_addr !== 8'h00 || ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ram: addr=%h we=%b expected 00 0", ram_addr, ram_we);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [4] = '{16'h0030, 16'h0033, 16'h0036, 16'h0039};
        pulse_start(8'h10, 9'd4);
        collect(20, 0, -1);
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d words expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got %h expected %h", i, got[i], exp_w[i]);
            end
        end
        checks++;
        if (first_valid != 2 || first_hs != 2 || last_hs != 5) begin
            errors++;
            $display("[TB] FAIL basic_timing: first_valid=%0d first_hs=%0d last_hs=%0d expected 2 2 5",
                     first_valid, first_hs, last_hs);
        end
        checks++;
        if (done_count != 1 || done_cyc != 6 || busy_at_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: count=%0d cycle=%0d busy=%b expected 1 6 0",
                     done_count, done_cyc, busy_at_done);
        end
        checks++;
        if (busy !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_idle: busy=%b we=%b expected 0 0", busy, ram_we);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_w [4] = '{16'h0030, 16'h0033, 16'h0036, 16'h0039};
        out_ready = 1'b0;
        pulse_start(8'h10, 9'd4);
        repeat (4) step();
        // Two words fetched, reads stalled with the FIFO full
        checks++;
        if (ram_addr !== 8'h11 || out_valid !== 1'b1 || value_out !== 16'h0030) begin
            errors++;
            $display("[TB] FAIL bp_stall: addr=%h valid=%b value=%h expected 11 1 0030",
                     ram_addr, out_valid, value_out);
        end
        collect(30, 1, -1);
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d words expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("[TB] FAIL bp_word%0d: got %h expected %h", i, got[i], exp_w[i]);
            end
        end
        checks++;
        if (stall_viol != 0) begin
            errors++;
            $display("[TB] FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol);
        end
        checks++;
        if (done_count != 1 || done_cyc != last_hs + 1 || last_hs != 6) begin
            errors++;
            $display("[TB] FAIL bp_done: count=%0d cycle=%0d last_hs=%0d expected 1 7 6",
                     done_count, done_cyc, last_hs);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [15:0] exp_w [4] = '{16'h02FA, 16'h02FD, 16'h0000, 16'h0003};
        pulse_start(8'hFE, 9'd4);
        collect(20, 0, -1);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
            checks++;
            if (addr_log[i] !== exp_a[i]) begin
                errors++;
                $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, addr_log[i], exp_a[i]);
            end
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("[TB] FAIL wrap_count: got %0d words expected 4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("[TB] FAIL wrap_word%0d: got %h expected %h", i, got[i], exp_w[i]);
            end
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("[TB] FAIL wrap_done: got %0d pulses expected 1", done_count);
        end
    endtask

    task automatic test_length_edges();
        int bad;
        pulse_start(8'h40, 9'd0);
        collect(6, 0, -1);
        checks++;
        if (busy_seen != 0 || first_valid != -1 || done_count != 0 || got.size() != 0) begin
            errors++;
            $display("[TB] FAIL len0_idle: busy=%0d valid_at=%0d done=%0d words=%0d expected 0 -1 0 0",
                     busy_seen, first_valid, done_count, got.size());
        end
        // Last issued address of the preceding wrap burst is held
        checks++;
        if (ram_addr !== 8'h01) begin
            errors++;
            $display("[TB] FAIL len0_addr: got %h expected 01", ram_addr);
        end
        pulse_start(8'h00, 9'd256);
        collect(270, 0, -1);
        checks++;
        if (got.size() != 256) begin
            errors++;
            $display("[TB] FAIL len256_count: got %0d words expected 256", got.size());
        end
        bad = 0;
        for (int i = 0; i < got.size() && i < 256; i++) begin
            if (got[i] !== 16'(i * 3)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL len256_words: got %0d wrong words expected 0", bad);
        end
        checks++;
        if (done_count != 1 || done_cyc != 258) begin
            errors++;
            $display("[TB] FAIL len256_done: count=%0d cycle=%0d expected 1 258", done_count, done_cyc);
        end
    endtask

    task automatic test_start_while_busy();
        int bad;
        pulse_start(8'h20, 9'd8);
        base_addr = 8'h80;
        length    = 9'd3;
        collect(25, 0, 3);
        checks++;
        if (got.size() != 8) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d words expected 8", got.size());
        end
        bad = 0;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            if (got[i] !== 16'((32 + i) * 3)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL restart_words: got %0d wrong words expected 0", bad);
        end
        checks++;
        if (done_count != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_done: count=%0d busy=%b expected 1 0", done_count, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] exp_w [3] = '{16'h000F, 16'h0012, 16'h0015};
        pulse_start(8'h30, 9'd8);
        collect(5, 0, -1);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got %0d words expected 3", got.size());
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ram_addr !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rstmid_state: valid=%b busy=%b done=%b addr=%h expected 0 0 0 00",
                     out_valid, busy, done, ram_addr);
        end
        collect(15, 0, -1);
        checks++;
        if (got.size() != 0 || done_count != 0 || busy_seen != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_quiet: words=%0d done=%0d busy=%0d expected 0 0 0",
                     got.size(), done_count, busy_seen);
        end
        pulse_start(8'h05, 9'd3);
        collect(15, 0, -1);
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("[TB] FAIL rstmid_new_count: got %0d words expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin
                errors++;
                $display("[TB] FAIL rstmid_new_word%0d: got %h expected %h", i, got[i], exp_w[i]);
            end
        end
        checks++;
        if (done_count != 1) begin
            errors++;
            $display("[TB] FAIL rstmid_new_done: got %0d pulses expected 1", done_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = 8'h00;
        length    = 9'd0;
        out_ready = 1'b0;
        step();

        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_length_edges();
        test_start_while_busy();
        test_reset_mid_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
